// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU operation sequencer: command opcodes, the
// ALU Operation encodings, the sequencer FSM state type and small decode
// helpers used by the top level.
//
// Optional feature macro: ALU_SEQ_ADDC_EN
//   defined   -> opcode 110 (ADDC) is legal; Carryin comes from the stored carry flag
//   undefined -> opcode 110 is treated as illegal
package alu_seq_pkg;

  localparam int DATA_W = 32;
  localparam int NREG   = 8;
  localparam int IDX_W  = 3;

  // Command opcodes (101 and 111 are always illegal)
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LI   = 3'b100;
  localparam logic [2:0] OP_ADDC = 3'b110;

  // ALU Operation select encodings
  localparam logic [1:0] ALUOP_AND = 2'b00;
  localparam logic [1:0] ALUOP_OR  = 2'b01;
  localparam logic [1:0] ALUOP_ADD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  typedef struct packed {
    logic [1:0] operation;
    logic       binvert;
    logic       carryin;
  } alu_ctrl_t;

  // True for opcodes the sequencer executes in the current build.
  function automatic logic op_is_legal(input logic [2:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_LI: legal = 1'b1;
`ifdef ALU_SEQ_ADDC_EN
      OP_ADDC: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  // True for opcodes whose ALU CarryOut becomes the new carry flag.
  function automatic logic op_sets_carry(input logic [2:0] op);
    logic sets;
    case (op)
      OP_ADD, OP_SUB: sets = 1'b1;
`ifdef ALU_SEQ_ADDC_EN
      OP_ADDC: sets = 1'b1;
`endif
      default: sets = 1'b0;
    endcase
    return sets;
  endfunction

  // ALU control for an opcode. LI and illegal opcodes leave the ALU idle (all 0).
  // SUB relies on the ALU inverting b itself; Carryin=1 completes the two's complement.
  function automatic alu_ctrl_t alu_ctrl_for(input logic [2:0] op, input logic carry_flag);
    alu_ctrl_t ctrl;
    ctrl = '{operation: 2'b00, binvert: 1'b0, carryin: 1'b0};
    case (op)
      OP_AND: ctrl = '{operation: ALUOP_AND, binvert: 1'b0, carryin: 1'b0};
      OP_OR:  ctrl = '{operation: ALUOP_OR,  binvert: 1'b0, carryin: 1'b0};
      OP_ADD: ctrl = '{operation: ALUOP_ADD, binvert: 1'b0, carryin: 1'b0};
      OP_SUB: ctrl = '{operation: ALUOP_ADD, binvert: 1'b1, carryin: 1'b1};
`ifdef ALU_SEQ_ADDC_EN
      OP_ADDC: ctrl = '{operation: ALUOP_ADD, binvert: 1'b0, carryin: carry_flag};
`endif
      default: ctrl = '{operation: 2'b00, binvert: 1'b0, carryin: 1'b0};
    endcase
`ifndef ALU_SEQ_ADDC_EN
    if (carry_flag) begin
      ctrl = ctrl; // the stored flag never reaches Carryin without ADDC
    end else begin
      ctrl = ctrl;
    end
`endif
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile
// NREG x DATA_W register file with two combinational read ports and one
// synchronous write port. Register 0 reads as zero and ignores writes.
// All registers clear asynchronously while rst_n is low.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low clear
//   we, waddr, wdata    synchronous write port
//   raddr_a / rdata_a   read port A (combinational)
//   raddr_b / rdata_b   read port B (combinational)
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem_r [NREG];

  // Register storage: async clear, write everything except r0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we && (waddr != 3'd0)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read ports with r0 hardwired to zero.
  always_comb begin
    rdata_a = {DATA_W{1'b0}};
    rdata_b = {DATA_W{1'b0}};
    if (raddr_a != 3'd0) begin
      rdata_a = mem_r[raddr_a];
    end else begin
      rdata_a = {DATA_W{1'b0}};
    end
    if (raddr_b != 3'd0) begin
      rdata_b = mem_r[raddr_b];
    end else begin
      rdata_b = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Command-driven micro-sequencer placed in front of an external 32-bit ALU.
// A command is accepted in IDLE, operands are read from the internal register
// file at acceptance and presented to the ALU for one EXEC cycle, and at the
// end of EXEC the result is written back and returned on the response port.
//
// Optional feature macro: ALU_SEQ_ADDC_EN (enables opcode 110, add with carry).
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_rd/rs/rt, cmd_imm command fields
//   alu_a, alu_b, alu_operation,
//   alu_binvert, alu_carryin      ALU drive (all 0 outside EXEC)
//   alu_result, alu_carryout      ALU outputs sampled at the end of EXEC
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_carry, rsp_err  response payload
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_rs,
  input  logic [2:0]  cmd_rt,
  input  logic [31:0] cmd_imm,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_operation,
  output logic        alu_binvert,
  output logic        alu_carryin,
  input  logic [31:0] alu_result,
  input  logic        alu_carryout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_err
);

  state_t      state_r, state_nxt_s;
  logic        cmd_ready_r, rsp_valid_r;
  logic [2:0]  op_r, rd_r;
  logic [31:0] imm_r;
  logic [31:0] alu_a_r, alu_b_r;
  alu_ctrl_t   ctrl_r, ctrl_s;
  logic [31:0] rsp_data_r;
  logic        rsp_err_r, carry_r;
  logic [31:0] rf_a_s, rf_b_s, wdata_s;
  logic        accept_s, wr_en_s, drive_alu_s;

  assign accept_s = (state_r == ST_IDLE) && cmd_valid;

  alu_seq_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_en_s),
    .waddr   (rd_r),
    .wdata   (wdata_s),
    .raddr_a (cmd_rs),
    .rdata_a (rf_a_s),
    .raddr_b (cmd_rt),
    .rdata_b (rf_b_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Writeback path: LI writes its immediate, everything else the ALU result.
  // Only legal opcodes write, and only at the end of EXEC.
  always_comb begin
    drive_alu_s = 1'b0;
    wr_en_s     = 1'b0;
    wdata_s     = alu_result;
    ctrl_s      = alu_ctrl_for(cmd_op, carry_r);
    drive_alu_s = op_is_legal(cmd_op) && (cmd_op != OP_LI);
    if (state_r == ST_EXEC) begin
      wr_en_s = op_is_legal(op_r);
    end else begin
      wr_en_s = 1'b0;
    end
    if (op_r == OP_LI) begin
      wdata_s = imm_r;
    end else begin
      wdata_s = alu_result;
    end
  end

  // Handshake flags, registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      cmd_ready_r <= (state_nxt_s == ST_IDLE);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
    end
  end

  // Command latch, ALU drive registers, carry flag and response payload.
  // Operands are sampled at acceptance: the previous command's writeback has
  // already landed, so the copies are always current.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r       <= 3'b000;
      rd_r       <= 3'b000;
      imm_r      <= 32'h0000_0000;
      alu_a_r    <= 32'h0000_0000;
      alu_b_r    <= 32'h0000_0000;
      ctrl_r     <= '{operation: 2'b00, binvert: 1'b0, carryin: 1'b0};
      rsp_data_r <= 32'h0000_0000;
      rsp_err_r  <= 1'b0;
      carry_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r  <= cmd_op;
            rd_r  <= cmd_rd;
            imm_r <= cmd_imm;
            if (drive_alu_s) begin
              alu_a_r <= rf_a_s;
              alu_b_r <= rf_b_s;
              ctrl_r  <= ctrl_s;
            end else begin
              alu_a_r <= 32'h0000_0000;
              alu_b_r <= 32'h0000_0000;
              ctrl_r  <= '{operation: 2'b00, binvert: 1'b0, carryin: 1'b0};
            end
          end
        end
        ST_EXEC: begin
          alu_a_r <= 32'h0000_0000;
          alu_b_r <= 32'h0000_0000;
          ctrl_r  <= '{operation: 2'b00, binvert: 1'b0, carryin: 1'b0};
          if (op_is_legal(op_r)) begin
            rsp_data_r <= wdata_s;
            rsp_err_r  <= 1'b0;
          end else begin
            rsp_data_r <= 32'h0000_0000;
            rsp_err_r  <= 1'b1;
          end
          if (op_sets_carry(op_r)) begin
            carry_r <= alu_carryout;
          end
        end
        ST_RESP: begin
          rsp_data_r <= rsp_data_r;
        end
        default: begin
          alu_a_r <= 32'h0000_0000;
          alu_b_r <= 32'h0000_0000;
          ctrl_r  <= '{operation: 2'b00, binvert: 1'b0, carryin: 1'b0};
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_data      = rsp_data_r;
  assign rsp_carry     = carry_r;
  assign rsp_err       = rsp_err_r;
  assign alu_a         = alu_a_r;
  assign alu_b         = alu_b_r;
  assign alu_operation = ctrl_r.operation;
  assign alu_binvert   = ctrl_r.binvert;
  assign alu_carryin   = ctrl_r.carryin;

endmodule
